// File: rtl/mat_2x2_stream_adapter.sv
// Byte-stream front/back end for a combinational 2x2 matrix multiplier.
// Four operand bytes are assembled into one frame and applied to a..h in a
// single edge. After a fixed settle time, w,x,y,z are captured and streamed
// back out as four result bytes.
module mat_2x2_stream_adapter #(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [3:0] a,
    output logic [3:0] b,
    output logic [3:0] c,
    output logic [3:0] d,
    output logic [3:0] e,
    output logic [3:0] f,
    output logic [3:0] g,
    output logic [3:0] h,
    input  logic [7:0] w,
    input  logic [7:0] x,
    input  logic [7:0] y,
    input  logic [7:0] z,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       busy,
    output logic       frame_done
);

    localparam logic [1:0] ST_LOAD   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_SEND   = 2'd2;

    // Counter value on the edge that must capture the multiplier results.
    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

    logic [1:0]  state_q, state_d;
    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic [3:0]  settle_cnt_q, settle_cnt_d;
    logic [23:0] shadow_q, shadow_d;
    logic [31:0] ops_q, ops_d;
    logic [31:0] res_q, res_d;
    logic        frame_done_q, frame_done_d;

    logic        in_xfer;
    logic        out_xfer;

    // Handshake and status outputs derived from the current state.
    always_comb begin
        in_ready  = (state_q == ST_LOAD) && !reset;
        out_valid = (state_q == ST_SEND);
        busy      = !((state_q == ST_LOAD) && (byte_cnt_q == 2'd0));
        in_xfer   = in_valid && in_ready;
        out_xfer  = out_valid && out_ready;
        out_data  = 8'd0;
        if (out_valid) begin
            case (byte_cnt_q)
                2'd0:    out_data = res_q[31:24];
                2'd1:    out_data = res_q[23:16];
                2'd2:    out_data = res_q[15:8];
                default: out_data = res_q[7:0];
            endcase
        end
    end

    assign {a, b, c, d, e, f, g, h} = ops_q;
    assign frame_done               = frame_done_q;

    // Frame sequencing: load bytes, settle, then stream results.
    always_comb begin
        state_d      = state_q;
        byte_cnt_d   = byte_cnt_q;
        settle_cnt_d = settle_cnt_q;
        shadow_d     = shadow_q;
        ops_d        = ops_q;
        res_d        = res_q;
        frame_done_d = 1'b0;

        case (state_q)
            ST_LOAD: begin
                if (in_xfer) begin
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    case (byte_cnt_q)
                        2'd0: shadow_d[23:16] = in_data;
                        2'd1: shadow_d[15:8]  = in_data;
                        2'd2: shadow_d[7:0]   = in_data;
                        default: begin
                            // Whole operand set changes on one edge so the
                            // multiplier never sees a half-updated frame.
                            ops_d        = {shadow_q, in_data};
                            settle_cnt_d = 4'd0;
                            state_d      = ST_SETTLE;
                        end
                    endcase
                end
            end
            ST_SETTLE: begin
                settle_cnt_d = settle_cnt_q + 4'd1;
                if (settle_cnt_q == SETTLE_LAST) begin
                    res_d      = {w, x, y, z};
                    byte_cnt_d = 2'd0;
                    state_d    = ST_SEND;
                end
            end
            ST_SEND: begin
                if (out_xfer) begin
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        frame_done_d = 1'b1;
                        state_d      = ST_LOAD;
                    end
                end
            end
            default: begin
                state_d    = ST_LOAD;
                byte_cnt_d = 2'd0;
            end
        endcase
    end

    // State, operand and result registers with asynchronous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_LOAD;
            byte_cnt_q   <= 2'd0;
            settle_cnt_q <= 4'd0;
            shadow_q     <= 24'd0;
            ops_q        <= 32'd0;
            res_q        <= 32'd0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            byte_cnt_q   <= byte_cnt_d;
            settle_cnt_q <= settle_cnt_d;
            shadow_q     <= shadow_d;
            ops_q        <= ops_d;
            res_q        <= res_d;
            frame_done_q <= frame_done_d;
        end
    end

endmodule

// File: tb/tb_mat_2x2_stream_adapter.sv
// Bench for mat_2x2_stream_adapter: two instances (settle 1 and settle 3)
// share clock and reset; a select bit routes stimulus to one of them.
module tb_mat_2x2_stream_adapter;

    logic        clk;
    logic        reset;
    logic        sel;
    logic [7:0]  in_data_d;
    logic        in_valid_d;
    logic        out_ready_d;
    logic [31:0] noise;

    logic        in_valid1, in_ready1, out_valid1, busy1, frame_done1;
    logic [3:0]  a1, b1, c1, d1, e1, f1, g1, h1;
    logic [7:0]  w1, x1, y1, z1, out_data1;
    logic        in_valid3, in_ready3, out_valid3, busy3, frame_done3;
    logic [3:0]  a3, b3, c3, d3, e3, f3, g3, h3;
    logic [7:0]  w3, x3, y3, z3, out_data3;

    logic [31:0] obs_ops;
    logic [7:0]  obs_out_data;
    logic        obs_in_ready, obs_out_valid, obs_busy, obs_frame_done;

    int          checks;
    int          errors;
    int          carry;
    logic [31:0] cur_ops [2];

    // Behavioural 2x2 multiplier: element k of [[a,b],[c,d]] x [[e,f],[g,h]].
    function automatic logic [7:0] mm(input logic [31:0] ops, input int k);
        int n [8];
        for (int i = 0; i < 8; i++) n[i] = int'(ops[31-4*i -: 4]);
        case (k)
            0:       return 8'(n[0]*n[4] + n[1]*n[6]);
            1:       return 8'(n[0]*n[5] + n[1]*n[7]);
            2:       return 8'(n[2]*n[4] + n[3]*n[6]);
            default: return 8'(n[2]*n[5] + n[3]*n[7]);
        endcase
    endfunction

    assign in_valid3 = in_valid_d & sel;
    assign in_valid1 = in_valid_d & ~sel;
    assign w1 = mm({a1, b1, c1, d1, e1, f1, g1, h1}, 0) ^ noise[7:0];
    assign x1 = mm({a1, b1, c1, d1, e1, f1, g1, h1}, 1) ^ noise[15:8];
    assign y1 = mm({a1, b1, c1, d1, e1, f1, g1, h1}, 2) ^ noise[23:16];
    assign z1 = mm({a1, b1, c1, d1, e1, f1, g1, h1}, 3) ^ noise[31:24];
    assign w3 = mm({a3, b3, c3, d3, e3, f3, g3, h3}, 0) ^ noise[7:0];
    assign x3 = mm({a3, b3, c3, d3, e3, f3, g3, h3}, 1) ^ noise[15:8];
    assign y3 = mm({a3, b3, c3, d3, e3, f3, g3, h3}, 2) ^ noise[23:16];
    assign z3 = mm({a3, b3, c3, d3, e3, f3, g3, h3}, 3) ^ noise[31:24];

    assign obs_ops        = sel ? {a3, b3, c3, d3, e3, f3, g3, h3} : {a1, b1, c1, d1, e1, f1, g1, h1};
    assign obs_out_data   = sel ? out_data3 : out_data1;
    assign obs_in_ready   = sel ? in_ready3 : in_ready1;
    assign obs_out_valid  = sel ? out_valid3 : out_valid1;
    assign obs_busy       = sel ? busy3 : busy1;
    assign obs_frame_done = sel ? frame_done3 : frame_done1;

    mat_2x2_stream_adapter #(.SETTLE_CYCLES(1)) dut (
        .clk(clk), .reset(reset),
        .in_data(in_data_d), .in_valid(in_valid1), .in_ready(in_ready1),
        .a(a1), .b(b1), .c(c1), .d(d1), .e(e1), .f(f1), .g(g1), .h(h1),
        .w(w1), .x(x1), .y(y1), .z(z1),
        .out_data(out_data1), .out_valid(out_valid1), .out_ready(out_ready_d),
        .busy(busy1), .frame_done(frame_done1)
    );

    mat_2x2_stream_adapter #(.SETTLE_CYCLES(3)) dut3 (
        .clk(clk), .reset(reset),
        .in_data(in_data_d), .in_valid(in_valid3), .in_ready(in_ready3),
        .a(a3), .b(b3), .c(c3), .d(d3), .e(e3), .f(f3), .g(g3), .h(h3),
        .w(w3), .x(x3), .y(y3), .z(z3),
        .out_data(out_data3), .out_valid(out_valid3), .out_ready(out_ready_d),
        .busy(busy3), .frame_done(frame_done3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic reset_checks(input string tag);
        check({tag, "_out_valid"}, obs_out_valid, 0);
        check({tag, "_out_data"}, obs_out_data, 0);
        check({tag, "_frame_done"}, obs_frame_done, 0);
        check({tag, "_ops"}, obs_ops, 0);
        check({tag, "_busy"}, obs_busy, 0);
    endtask

    // Push one frame and collect its four results. abort_load / abort_send
    // return early (at a falling edge) once that many bytes have moved.
    task automatic do_frame(input logic [31:0] frame, input int gap_pct, input int bp_mode,
                            input bit hold_next, input logic [7:0] next_b0,
                            input int abort_load, input int abort_send);
        logic [7:0]  exp_q [4];
        logic [31:0] prev;
        int idx, cyc, edges, ridx, settle_exp;
        bit tog;
        prev = cur_ops[sel];
        settle_exp = sel ? 3 : 1;
        for (int k = 0; k < 4; k++) exp_q[k] = mm(frame, k);
        idx = carry;
        carry = 0;
        cyc = 0;
        while (idx < 4 && cyc < 200) begin
            @(negedge clk);
            if (idx == abort_load) return;
            check("in_ready_load", obs_in_ready, 1);
            check("out_valid_load", obs_out_valid, 0);
            check("frame_done_idle", obs_frame_done, 0);
            check("ops_hold", obs_ops, prev);
            check("busy_load", obs_busy, (idx != 0));
            in_valid_d = ($urandom_range(0, 99) >= gap_pct);
            in_data_d  = frame[31-8*idx -: 8];
            @(posedge clk);
            if (in_valid_d) idx++;
            cyc++;
        end
        check("load_done", idx, 4);
        cur_ops[sel] = frame;

        @(negedge clk);
        if (hold_next) begin
            in_valid_d = 1'b1;
            in_data_d  = next_b0;
        end else begin
            in_valid_d = 1'b0;
        end
        check("ops_new", obs_ops, frame);
        edges = 0;
        while (!obs_out_valid && edges < 20) begin
            check("in_ready_settle", obs_in_ready, 0);
            check("busy_settle", obs_busy, 1);
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        check("settle_edges", edges, settle_exp);

        ridx = 0;
        cyc = 0;
        tog = 1'b1;
        while (ridx < 4 && cyc < 200) begin
            if (ridx == abort_send) return;
            noise = $urandom;
            check("out_valid_send", obs_out_valid, 1);
            check("in_ready_send", obs_in_ready, 0);
            check("frame_done_send", obs_frame_done, 0);
            check($sformatf("out_data_%0d", ridx), obs_out_data, exp_q[ridx]);
            case (bp_mode)
                0:       out_ready_d = 1'b1;
                1:       begin out_ready_d = tog; tog = ~tog; end
                default: out_ready_d = ($urandom_range(0, 2) == 0);
            endcase
            @(posedge clk);
            if (out_ready_d) ridx++;
            cyc++;
            @(negedge clk);
        end
        noise = 32'd0;
        check("send_done", ridx, 4);
        check("frame_done_pulse", obs_frame_done, 1);
        check("out_valid_end", obs_out_valid, 0);
        check("in_ready_end", obs_in_ready, 1);
        check("busy_end", obs_busy, 0);
        if (hold_next) begin
            @(posedge clk);
            carry = 1;
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        carry = 0;
        sel = 1'b0;
        noise = 32'd0;
        in_data_d = 8'd0;
        in_valid_d = 1'b0;
        out_ready_d = 1'b0;
        cur_ops[0] = 32'd0;
        cur_ops[1] = 32'd0;
        reset = 1'b1;
        #2;
        reset_checks("por");
        #10.5;
        reset = 1'b0;

        // Basic frame, no backpressure.
        do_frame(32'h12345678, 0, 0, 1'b0, 8'h00, -1, -1);
        check("ops_f1", obs_ops, 32'h12345678);

        // Back-to-back frames with in_valid held high throughout.
        do_frame(32'h55555555, 0, 0, 1'b1, 8'h43, -1, -1);
        do_frame(32'h43218765, 0, 0, 1'b0, 8'h00, -1, -1);

        // Alternating and random backpressure.
        do_frame(32'h01200120, 0, 1, 1'b0, 8'h00, -1, -1);
        do_frame($urandom, 30, 2, 1'b0, 8'h00, -1, -1);

        // Gaps on the input stream.
        do_frame(32'h12545578, 50, 0, 1'b0, 8'h00, -1, -1);

        // Asynchronous reset after two operand bytes.
        do_frame(32'hA5C3E1F7, 0, 0, 1'b0, 8'h00, 2, -1);
        in_valid_d = 1'b0;
        #2 reset = 1'b1;
        #1 reset_checks("rst_load");
        @(negedge clk);
        reset_checks("rst_load_hold");
        reset = 1'b0;
        cur_ops[0] = 32'd0;
        cur_ops[1] = 32'd0;
        carry = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("no_valid_after_rst", obs_out_valid, 0);
        end

        // Asynchronous reset in the middle of the result stream.
        do_frame(32'h9ABCDEF1, 0, 0, 1'b0, 8'h00, -1, 1);
        noise = 32'd0;
        out_ready_d = 1'b0;
        #2 reset = 1'b1;
        #1 reset_checks("rst_send");
        @(negedge clk);
        reset = 1'b0;
        cur_ops[0] = 32'd0;
        cur_ops[1] = 32'd0;
        carry = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("no_valid_after_rst2", obs_out_valid, 0);
        end
        do_frame(32'h12345678, 0, 0, 1'b0, 8'h00, -1, -1);

        // Longer settle time on the second instance.
        @(negedge clk);
        sel = 1'b1;
        do_frame(32'h12345678, 0, 0, 1'b0, 8'h00, -1, -1);
        do_frame($urandom, 20, 2, 1'b0, 8'h00, -1, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
